// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, fixed XLEN+2 cycle latency from accepted start to done.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
        return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_f3;
    logic [XLEN-1:0]     r_opnd;   // multiplicand magnitude or divisor magnitude
    logic [2*XLEN-1:0]   r_acc;    // product, or {remainder, quotient}
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_bzero;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_result;

    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_sh;
    logic [XLEN+1:0]     w_div_sub;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_rem;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix;

    // Operand sign decode and magnitude conversion for a new request
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (funct3)
            3'b001:         begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            3'b010:         begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
            3'b100, 3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            default:        begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
        endcase
        w_neg_a = w_a_signed & op_a[XLEN-1];
        w_neg_b = w_b_signed & op_b[XLEN-1];
        w_mag_a = w_neg_a ? neg_w(op_a) : op_a;
        w_mag_b = w_neg_b ? neg_w(op_b) : op_b;
    end

    // One iteration of shift-add multiply and of restoring divide
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]}
                   + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        w_div_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_sub  = {1'b0, w_div_sh} - {2'b00, r_opnd};
        w_div_ge   = ~w_div_sub[XLEN+1];
        w_div_rem  = w_div_ge ? w_div_sub[XLEN-1:0] : w_div_sh[XLEN-1:0];
        w_div_next = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};
    end

    // Sign correction and result selection; divide-by-zero remainder
    // already equals op_a through the magnitude/sign path
    always_comb begin
        w_prod = r_neg_q ? neg_dw(r_acc) : r_acc;
        w_quo  = r_neg_q ? neg_w(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
        w_rem  = r_neg_r ? neg_w(r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
        case (r_f3)
            3'b000:                 w_fix = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix = r_bzero ? {XLEN{1'b1}} : w_quo;
            3'b110, 3'b111:         w_fix = w_rem;
            default:                w_fix = {XLEN{1'b0}};
        endcase
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_f3     <= 3'b000;
            r_opnd   <= {XLEN{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_f3    <= funct3;
                        r_opnd  <= funct3[2] ? w_mag_b : w_mag_a;
                        r_acc   <= {{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_bzero <= (op_b == {XLEN{1'b0}});
                        r_cnt   <= CW'(XLEN - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_acc <= r_f3[2] ? w_div_next : w_mul_next;
                    if (r_cnt == {CW{1'b0}}) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_FIX: begin
                    r_result <= w_fix;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, handshake, reset.
module tb_muldiv_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int nvec = 0;
    int nerr = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op; optionally pulse a conflicting start while busy.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag, input bit inject);
        int k;
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && k < 60) begin
            if (inject && k == 5) begin
                start = 1'b1; funct3 = 3'b000; op_a = 32'h12345678; op_b = 32'h00000003;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, " latency"}, k, 32'd34);
        check({tag, " result"}, result, exp);
    endtask

    initial begin
        int k;
        int seen;
        rst_n = 1'b0; start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'd9;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1; start = 1'b0;

        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "MUL",      1'b0);
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "MULH",     1'b0);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "MULHU",    1'b0);
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "MULHSU",   1'b0);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "DIV",      1'b0);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "REM",      1'b0);
        run_op(3'b101, 32'd100,      32'd7,        32'd14,       "DIVU",     1'b0);
        run_op(3'b111, 32'd100,      32'd7,        32'd2,        "REMU",     1'b0);
        run_op(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, "DIV0",     1'b0);
        run_op(3'b111, 32'd5,        32'd0,        32'd5,        "REMU0",    1'b0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "DIVOVF",   1'b0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        "REMOVF",   1'b0);
        run_op(3'b101, 32'd1000,     32'd10,       32'd100,      "IGNSTART", 1'b1);

        // Back-to-back: restart in the done cycle
        run_op(3'b101, 32'd100, 32'd7, 32'd14, "B2B first", 1'b0);
        check("B2B done pulse", {31'd0, done}, 32'd1);
        funct3 = 3'b111; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        check("B2B busy", {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && k < 60) begin
            if (k == 20) check("B2B hold", result, 32'd14);
            @(negedge clk);
            k++;
        end
        check("B2B latency", k, 32'd34);
        check("B2B result", result, 32'd2);

        // Reset in the middle of a divide
        @(negedge clk);
        funct3 = 3'b100; op_a = 32'd77; op_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst result", result, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("midrst no done", seen, 32'd0);
        run_op(3'b100, 32'd77, 32'd5, 32'd15, "post-reset DIV", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
